csa_adder_tree_pipe: RTL and testbench
======================================

Name: csa_adder_tree_pipe

Overview:
- Parametrised, pipelined multi-operand unsigned adder.
- Successor to the fixed 4-input carry-save adder; used in the neuron and synapse summation paths.
- Reduces p_num_inputs operands through a tree of registered 4-input carry-save stages.
- Per-operand masking; valid/ready flow control with global stall.

Parameters:
p_input_width, 14, width of each unsigned operand
p_num_inputs, 16, operand count; legal values 4, 8, 16, 32, 64
p_acc_width, 24, accumulator width; used only with CSA_TREE_ACC_EN

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  synchronous active-low reset
i_data  input  p_num_inputs*p_input_width  packed operands; operand k at bits [k*W +: W]
i_mask  input  p_num_inputs  1 = operand included, 0 = operand forced to zero
i_valid  input  1  input beat valid
o_ready  output  1  block can accept a beat this cycle
o_sum  output  p_input_width+clog2(p_num_inputs)  sum of unmasked operands
o_valid  output  1  o_sum valid
i_ready  input  1  downstream accepts o_sum
i_last  input  1  last beat of an accumulation group; CSA_TREE_ACC_EN only
o_acc  output  p_acc_width  accumulated group sum; CSA_TREE_ACC_EN only

Behaviour:
Reset and flow control:
- Reset (i_rst_n=0 at a clock edge): every stage valid bit, o_valid, o_sum and o_acc clear to 0. o_ready reads 1 in the first cycle after reset.
- Reset mid-operation discards all in-flight beats. Stage data registers also clear.
- Levels: L = ceil(log4(p_num_inputs)), giving 1 for 4, 2 for 8/16, 3 for 32/64.
- Each level groups operands in fours, padding the last group with zeros.
- Each group: 4-input carry-save reduction (XOR/AND sum plus two shifted carry vectors), then a final add, then a register.
- Each level widens its result by 2 bits. The final result is truncated to the o_sum width, which is lossless for unsigned inputs.
- Pipeline enable: en = ~o_valid | i_ready, and o_ready = en.
  - When en=1 all stages advance together.
  - When en=0 all stages hold data and valid bits.
- A beat is accepted when i_valid & o_ready. Its result appears with o_valid=1 exactly L cycles later, absent stalls.
- Bubbles are not collapsed. A stall freezes the entire pipe.
- o_valid and o_sum hold stable while o_valid=1 and i_ready=0.
- Throughput: 1 beat per cycle while i_ready=1.
- Masking is applied at input capture. All-zero mask gives o_sum=0 with o_valid still asserted.
- The i_data/i_mask value is a don't-care when i_valid=0. The stage valid bit is 0 and the stage data is unconstrained.

Optional Feature:
- CSA_TREE_ACC_EN defined:
  - Adds ports i_last and o_acc.
  - i_last travels down the pipe alongside valid.
  - An extra accumulator stage adds each emerging tree result into a p_acc_width register, wrapping modulo 2^p_acc_width.
  - o_valid asserts only for a beat whose i_last=1. At that point o_acc = previous partial + this result.
  - The accumulator clears to 0 on that same handshake, so the next group starts at 0.
  - Latency becomes L+1.
  - o_sum still presents the tree result of the last beat.
- CSA_TREE_ACC_EN undefined:
  - i_last and o_acc ports are absent.
  - Every accepted beat produces one o_valid.

Decomposition:
- Shared package csa_pkg holds:
  - function clog4 (level count)
  - localparam helpers for per-level width (W+2*level) and per-level group count (ceil(n/4))
- Sub-module csa_adder_4in_reg: one registered 4-input carry-save group with enable and synchronous active-low reset. It is instantiated by generate loops per level.

Test Plan:
- N=16, W=14, all mask 1, all operands 16383, i_ready=1 -> o_sum=262128 after 2 cycles; o_ready stays 1.
- N=16, operands k+1 (1..16), i_mask=16'h00FF -> o_sum=36. With i_mask=0 -> o_sum=0 and o_valid=1.
- Back-to-back beats with operand values 1, 2, 3 (all operands equal, N=4) -> o_sum 4, 8, 12 on consecutive cycles. Deassert i_ready for 3 cycles mid-stream -> o_sum=8 held stable, o_ready=0, no beat lost or duplicated.
- N=8 (padding case), operands 1..8 -> o_sum=36 at latency 2.
- Assert i_rst_n=0 for one cycle with 2 beats in flight -> o_valid=0 next cycle and no stale result ever emerges.
- With CSA_TREE_ACC_EN: p_acc_width=24, N=4, operands all 1000.
  - Beats 1–3, last on beat 3 -> single o_valid with o_acc=12000.
  - Next group: 1 beat with i_last=1 -> o_acc=4000.
  - Wrap check: p_acc_width=16, 20 beats of 4×16383 -> o_acc=1310640 mod 65536=65456.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared helpers for the pipelined carry-save adder tree: level count, per-level
// operand width and operand/group counts.
package csa_pkg;

  function automatic int clog4(input int n);
    int l;
    int c;
    l = 0;
    c = 1;
    for (int i = 0; i < 16; i++) begin
      if (c < n) begin
        c = c * 4;
        l = l + 1;
      end
    end
    return l;
  endfunction

  function automatic int lvl_width(input int w, input int lvl);
    return w + 2 * lvl;
  endfunction

  function automatic int lvl_groups(input int n);
    return (n + 3) / 4;
  endfunction

  // Number of operands entering a given level of the tree.
  function automatic int lvl_count(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) c = (c + 3) / 4;
    return c;
  endfunction

endpackage

// File: rtl/csa_adder_4in_reg.sv
// One registered 4-input carry-save group: two 3:2 compressor layers, a final
// carry-propagate add and an enabled, synchronously cleared result register.
module csa_adder_4in_reg #(
  parameter int p_in_width = 14
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [p_in_width-1:0] i_a,
  input  logic [p_in_width-1:0] i_b,
  input  logic [p_in_width-1:0] i_c,
  input  logic [p_in_width-1:0] i_d,
  output logic [p_in_width+1:0] o_q
);

  localparam int OW = p_in_width + 2;

  logic [OW-1:0] a, b, c, d;
  logic [OW-1:0] s1, c1, s2, c2;
  logic [OW-1:0] q_d, q_q;

  assign a = OW'(i_a);
  assign b = OW'(i_b);
  assign c = OW'(i_c);
  assign d = OW'(i_d);

  // Carry bits shifted out of the top are always zero: 4 operands fit in W+2 bits.
  assign s1  = a ^ b ^ c;
  assign c1  = ((a & b) | (a & c) | (b & c)) << 1;
  assign s2  = s1 ^ c1 ^ d;
  assign c2  = ((s1 & c1) | (s1 & d) | (c1 & d)) << 1;
  assign q_d = s2 + c2;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) q_q <= '0;
    else if (i_en) q_q <= q_d;
  end

  assign o_q = q_q;

endmodule

// File: rtl/csa_adder_tree_pipe.sv
// Pipelined multi-operand unsigned adder built from registered 4-input CSA groups.
// Optional group accumulator stage enabled by defining CSA_TREE_ACC_EN.
module csa_adder_tree_pipe
  import csa_pkg::*;
#(
  parameter int p_input_width = 14,
  parameter int p_num_inputs  = 16,
  parameter int p_acc_width   = 24
) (
  input  logic                                              i_clk,
  input  logic                                              i_rst_n,
  input  logic [p_num_inputs*p_input_width-1:0]             i_data,
  input  logic [p_num_inputs-1:0]                           i_mask,
  input  logic                                              i_valid,
  output logic                                              o_ready,
  output logic [p_input_width+$clog2(p_num_inputs)-1:0]     o_sum,
  output logic                                              o_valid,
`ifdef CSA_TREE_ACC_EN
  input  logic                                              i_last,
  output logic [p_acc_width-1:0]                            o_acc,
`endif
  input  logic                                              i_ready
);

  localparam int L  = clog4(p_num_inputs);
  localparam int W  = p_input_width;
  localparam int SW = p_input_width + $clog2(p_num_inputs);
  localparam int MW = lvl_width(p_input_width, L);

  logic              en;
  logic [L-1:0]      vld_q, vld_d;
  logic [MW-1:0]     lvl_data [L+1][p_num_inputs];
  logic [SW-1:0]     tree_sum;

  assign en      = ~o_valid | i_ready;
  assign o_ready = en;

  for (genvar k = 0; k < p_num_inputs; k++) begin : g_in
    assign lvl_data[0][k] = i_mask[k] ? MW'(i_data[k*W +: W]) : '0;
  end

  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int NI = lvl_count(p_num_inputs, l);
    localparam int NG = lvl_groups(NI);
    localparam int IW = lvl_width(W, l);
    for (genvar g = 0; g < p_num_inputs; g++) begin : g_grp
      if (g < NG) begin : g_used
        logic [IW-1:0] op [4];
        logic [IW+1:0] q;
        for (genvar j = 0; j < 4; j++) begin : g_op
          if (4 * g + j < NI) begin : g_real
            assign op[j] = lvl_data[l][4*g+j][IW-1:0];
          end else begin : g_zero
            assign op[j] = '0;
          end
        end
        csa_adder_4in_reg #(.p_in_width(IW)) u_grp (
          .i_clk   (i_clk),
          .i_rst_n (i_rst_n),
          .i_en    (en),
          .i_a     (op[0]),
          .i_b     (op[1]),
          .i_c     (op[2]),
          .i_d     (op[3]),
          .o_q     (q)
        );
        assign lvl_data[l+1][g] = MW'(q);
      end else begin : g_pad
        assign lvl_data[l+1][g] = '0;
      end
    end
  end

  assign tree_sum = lvl_data[L][0][SW-1:0];

  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = i_valid;
    for (int l = 1; l < L; l++) vld_d[l] = vld_q[l-1];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) vld_q <= '0;
    else if (en) vld_q <= vld_d;
  end

`ifdef CSA_TREE_ACC_EN
  logic [L-1:0]             last_q, last_d;
  logic [p_acc_width-1:0]   part_q, part_d, acc_q, acc_d, acc_nxt;
  logic [SW-1:0]            sum_q, sum_d;
  logic                     ovld_q, ovld_d;

  always_comb begin
    last_d    = last_q;
    last_d[0] = i_last;
    for (int l = 1; l < L; l++) last_d[l] = last_q[l-1];
  end

  // The partial sum restarts at zero on the same beat that publishes a group total.
  always_comb begin
    part_d  = part_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    ovld_d  = 1'b0;
    acc_nxt = part_q + p_acc_width'(tree_sum);
    if (vld_q[L-1]) begin
      sum_d = tree_sum;
      if (last_q[L-1]) begin
        acc_d  = acc_nxt;
        part_d = '0;
        ovld_d = 1'b1;
      end else begin
        part_d = acc_nxt;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      last_q <= '0;
      part_q <= '0;
      acc_q  <= '0;
      sum_q  <= '0;
      ovld_q <= 1'b0;
    end else if (en) begin
      last_q <= last_d;
      part_q <= part_d;
      acc_q  <= acc_d;
      sum_q  <= sum_d;
      ovld_q <= ovld_d;
    end
  end

  assign o_valid = ovld_q;
  assign o_sum   = sum_q;
  assign o_acc   = acc_q;
`else
  assign o_valid = vld_q[L-1];
  assign o_sum   = tree_sum;
`endif

endmodule

// File: tb/tb_csa_adder_tree_pipe.sv
// Directed bench for csa_adder_tree_pipe (N=16, N=4, N=8 instances; accumulator
// checks added when CSA_TREE_ACC_EN is defined).
module tb_csa_adder_tree_pipe;

`ifdef CSA_TREE_ACC_EN
  localparam int ACC_LAT = 1;
`else
  localparam int ACC_LAT = 0;
`endif
  localparam int LAT16 = 2 + ACC_LAT;
  localparam int LAT4  = 1 + ACC_LAT;
  localparam int LAT8  = 2 + ACC_LAT;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [16*14-1:0] d16;  logic [15:0] m16;  logic v16, r16, ordy16, ov16;  logic [17:0] sum16;
  logic [4*14-1:0]  d4;   logic [3:0]  m4;   logic v4,  r4,  ordy4,  ov4;   logic [15:0] sum4;
  logic [8*14-1:0]  d8;   logic [7:0]  m8;   logic v8,  r8,  ordy8,  ov8;   logic [16:0] sum8;
  logic l16, l4, l8;
`ifdef CSA_TREE_ACC_EN
  logic [23:0] acc16, acc4, acc8;
  logic [4*14-1:0] dw; logic vw, rw, lw, ordyw, ovw; logic [15:0] sumw, accw;
`endif

  csa_adder_tree_pipe #(.p_input_width(14), .p_num_inputs(16), .p_acc_width(24)) u16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(d16), .i_mask(m16), .i_valid(v16),
    .o_ready(ordy16), .o_sum(sum16), .o_valid(ov16),
`ifdef CSA_TREE_ACC_EN
    .i_last(l16), .o_acc(acc16),
`endif
    .i_ready(r16));

  csa_adder_tree_pipe #(.p_input_width(14), .p_num_inputs(4), .p_acc_width(24)) u4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(d4), .i_mask(m4), .i_valid(v4),
    .o_ready(ordy4), .o_sum(sum4), .o_valid(ov4),
`ifdef CSA_TREE_ACC_EN
    .i_last(l4), .o_acc(acc4),
`endif
    .i_ready(r4));

  csa_adder_tree_pipe #(.p_input_width(14), .p_num_inputs(8), .p_acc_width(24)) u8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(d8), .i_mask(m8), .i_valid(v8),
    .o_ready(ordy8), .o_sum(sum8), .o_valid(ov8),
`ifdef CSA_TREE_ACC_EN
    .i_last(l8), .o_acc(acc8),
`endif
    .i_ready(r8));

`ifdef CSA_TREE_ACC_EN
  csa_adder_tree_pipe #(.p_input_width(14), .p_num_inputs(4), .p_acc_width(16)) u4w (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(dw), .i_mask(4'hF), .i_valid(vw),
    .o_ready(ordyw), .o_sum(sumw), .o_valid(ovw), .i_last(lw), .o_acc(accw),
    .i_ready(rw));
`endif

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    v16 = 0; v4 = 0; v8 = 0; r16 = 1; r4 = 1; r8 = 1; l16 = 1; l4 = 1; l8 = 1;
    d16 = '0; d4 = '0; d8 = '0; m16 = '1; m4 = '1; m8 = '1;
`ifdef CSA_TREE_ACC_EN
    dw = '0; vw = 0; rw = 1; lw = 0;
`endif
    step; step;
    rst_n = 1'b1;
    step;
    n_cmp++; if (ov16 !== 1'b0) begin n_err++; $display("FAIL reset_ov16: got %0d expected 0", ov16); end
    n_cmp++; if (sum16 !== 18'd0) begin n_err++; $display("FAIL reset_sum16: got %0d expected 0", sum16); end
    n_cmp++; if (ordy16 !== 1'b1) begin n_err++; $display("FAIL reset_ready16: got %0d expected 1", ordy16); end
    n_cmp++; if (ov4 !== 1'b0) begin n_err++; $display("FAIL reset_ov4: got %0d expected 0", ov4); end
    n_cmp++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL reset_ov8: got %0d expected 0", ov8); end
`ifdef CSA_TREE_ACC_EN
    n_cmp++; if (acc4 !== 24'd0) begin n_err++; $display("FAIL reset_acc4: got %0d expected 0", acc4); end
`endif
  endtask

  task automatic test_full_scale;
    for (int k = 0; k < 16; k++) d16[k*14 +: 14] = 14'd16383;
    m16 = 16'hFFFF; v16 = 1; l16 = 1; r16 = 1;
    for (int c = 1; c <= LAT16; c++) begin
      step;
      v16 = 0;
      n_cmp++; if (ordy16 !== 1'b1) begin n_err++; $display("FAIL full_ready_c%0d: got %0d expected 1", c, ordy16); end
      if (c < LAT16) begin
        n_cmp++; if (ov16 !== 1'b0) begin n_err++; $display("FAIL full_early_valid_c%0d: got %0d expected 0", c, ov16); end
      end
    end
    n_cmp++; if (ov16 !== 1'b1) begin n_err++; $display("FAIL full_valid: got %0d expected 1", ov16); end
    n_cmp++; if (sum16 !== 18'd262128) begin n_err++; $display("FAIL full_sum: got %0d expected 262128", sum16); end
    step;
  endtask

  task automatic test_mask;
    logic [15:0] masks [2];
    logic [17:0] exp_sum [2];
    masks[0] = 16'h00FF; exp_sum[0] = 18'd36;
    masks[1] = 16'h0000; exp_sum[1] = 18'd0;
    for (int k = 0; k < 16; k++) d16[k*14 +: 14] = 14'(k + 1);
    for (int t = 0; t < 2; t++) begin
      m16 = masks[t]; v16 = 1; l16 = 1;
      step;
      v16 = 0;
      for (int c = 2; c <= LAT16; c++) step;
      n_cmp++; if (ov16 !== 1'b1) begin n_err++; $display("FAIL mask%0d_valid: got %0d expected 1", t, ov16); end
      n_cmp++; if (sum16 !== exp_sum[t]) begin n_err++; $display("FAIL mask%0d_sum: got %0d expected %0d", t, sum16, exp_sum[t]); end
      step;
    end
  endtask

  task automatic test_back_to_back;
    int in_idx = 0;
    int out_idx = 0;
    int stalls = 0;
    m4 = 4'hF; l4 = 1;
    for (int cyc = 0; cyc < 40 && out_idx < 3; cyc++) begin
      v4 = (in_idx < 3);
      for (int k = 0; k < 4; k++) d4[k*14 +: 14] = 14'(in_idx + 1);
      r4 = 1;
      if (ov4 && out_idx == 1 && stalls < 3) r4 = 0;
      #1;
      if (!r4) begin
        stalls++;
        n_cmp++; if (sum4 !== 16'd8) begin n_err++; $display("FAIL b2b_stall_sum_%0d: got %0d expected 8", stalls, sum4); end
        n_cmp++; if (ordy4 !== 1'b0) begin n_err++; $display("FAIL b2b_stall_ready_%0d: got %0d expected 0", stalls, ordy4); end
      end
      if (ov4 && r4) begin
        n_cmp++;
        if (sum4 !== 16'(4 * (out_idx + 1))) begin
          n_err++; $display("FAIL b2b_sum_%0d: got %0d expected %0d", out_idx, sum4, 4 * (out_idx + 1));
        end
        out_idx++;
      end
      if (v4 && ordy4) in_idx++;
      step;
    end
    v4 = 0; r4 = 1;
    n_cmp++; if (out_idx != 3) begin n_err++; $display("FAIL b2b_count: got %0d expected 3", out_idx); end
    n_cmp++; if (stalls != 3) begin n_err++; $display("FAIL b2b_stalls: got %0d expected 3", stalls); end
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (ov4 !== 1'b0) begin n_err++; $display("FAIL b2b_dup_c%0d: got %0d expected 0", c, ov4); end
      step;
    end
  endtask

  task automatic test_padding;
    logic [16:0] exp_sum [2];
    exp_sum[0] = 17'd36; exp_sum[1] = 17'd131064;
    m8 = 8'hFF; l8 = 1; r8 = 1;
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < 8; k++) d8[k*14 +: 14] = (t == 0) ? 14'(k + 1) : 14'd16383;
      v8 = 1;
      step;
      v8 = 0;
      n_cmp++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL pad%0d_early: got %0d expected 0", t, ov8); end
      for (int c = 2; c <= LAT8; c++) step;
      n_cmp++; if (ov8 !== 1'b1) begin n_err++; $display("FAIL pad%0d_valid: got %0d expected 1", t, ov8); end
      n_cmp++; if (sum8 !== exp_sum[t]) begin n_err++; $display("FAIL pad%0d_sum: got %0d expected %0d", t, sum8, exp_sum[t]); end
      step;
    end
  endtask

  task automatic test_reset_flush;
    m16 = 16'hFFFF; r16 = 1; l16 = 1;
    for (int k = 0; k < 16; k++) d16[k*14 +: 14] = 14'd1;
    v16 = 1;
    step;
    for (int k = 0; k < 16; k++) d16[k*14 +: 14] = 14'd2;
    step;
    v16 = 0; rst_n = 0;
    step;
    rst_n = 1;
    n_cmp++; if (ov16 !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0d expected 0", ov16); end
    n_cmp++; if (sum16 !== 18'd0) begin n_err++; $display("FAIL flush_sum: got %0d expected 0", sum16); end
    for (int c = 0; c < 6; c++) begin
      step;
      n_cmp++; if (ov16 !== 1'b0) begin n_err++; $display("FAIL flush_stale_c%0d: got %0d expected 0", c, ov16); end
    end
  endtask

`ifdef CSA_TREE_ACC_EN
  task automatic test_acc_groups;
    int nv;
    m4 = 4'hF; r4 = 1;
    for (int k = 0; k < 4; k++) d4[k*14 +: 14] = 14'd1000;
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      v4 = (c < 3); l4 = (c == 2);
      step;
      if (ov4) begin
        nv++;
        n_cmp++; if (acc4 !== 24'd12000) begin n_err++; $display("FAIL acc_grp1: got %0d expected 12000", acc4); end
        n_cmp++; if (sum4 !== 16'd4000) begin n_err++; $display("FAIL acc_grp1_sum: got %0d expected 4000", sum4); end
      end
    end
    n_cmp++; if (nv != 1) begin n_err++; $display("FAIL acc_grp1_count: got %0d expected 1", nv); end
    nv = 0;
    for (int c = 0; c < 8; c++) begin
      v4 = (c == 0); l4 = (c == 0);
      step;
      if (ov4) begin
        nv++;
        n_cmp++; if (acc4 !== 24'd4000) begin n_err++; $display("FAIL acc_grp2: got %0d expected 4000", acc4); end
      end
    end
    n_cmp++; if (nv != 1) begin n_err++; $display("FAIL acc_grp2_count: got %0d expected 1", nv); end
    v4 = 0; l4 = 1;
  endtask

  task automatic test_acc_wrap;
    int nv = 0;
    rw = 1;
    for (int k = 0; k < 4; k++) dw[k*14 +: 14] = 14'd16383;
    for (int c = 0; c < 30; c++) begin
      vw = (c < 20); lw = (c == 19);
      step;
      if (ovw) begin
        nv++;
        n_cmp++; if (accw !== 16'd65456) begin n_err++; $display("FAIL acc_wrap: got %0d expected 65456", accw); end
        n_cmp++; if (sumw !== 16'd65532) begin n_err++; $display("FAIL acc_wrap_sum: got %0d expected 65532", sumw); end
      end
    end
    n_cmp++; if (nv != 1) begin n_err++; $display("FAIL acc_wrap_count: got %0d expected 1", nv); end
    vw = 0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_full_scale;
    test_mask;
    test_back_to_back;
    test_padding;
    test_reset_flush;
`ifdef CSA_TREE_ACC_EN
    test_acc_groups;
    test_acc_wrap;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
